minmax_scanner: RTL and testbench
=================================

Name: minmax_scanner

Overview:
Parametrised successor to the single-purpose max-finder controller. It combines the FSM and the datapath in one block. On a start pulse it scans an inclusive address range of a synchronous-read memory and returns the extreme value and the address where it occurs. The extreme is max or min, under a signed or unsigned compare, selected per run. It sits between a host sequencer (start/done handshake) and a memory read port with configurable read latency.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, memory address width in bits
RD_LAT, 1, cycles from mem_rd/mem_addr to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
mode_min  in  1  0 = find max, 1 = find min; latched at start
is_signed  in  1  1 = two's-complement compare; latched at start
first_addr  in  ADDR_W  first address of range; latched at start
last_addr  in  ADDR_W  last address of range (inclusive); latched at start
mem_addr  out  ADDR_W  read address, registered
mem_rd  out  1  read strobe, one cycle per element
mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_rd
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when result is valid
err  out  1  set with done when first_addr > last_addr; held until next start
result  out  DATA_W  extreme value; held until next accepted start
result_addr  out  ADDR_W  address of extreme value; held until next accepted start

Behaviour:
- Reset: all outputs 0, FSM to IDLE, latched config cleared. Reset mid-scan aborts the scan immediately. No done is issued.
- States: IDLE, ISSUE, WAIT, CMP, FIN.
- IDLE: busy=0. start=1 latches config and sets cur_addr=first_addr.
  - If first_addr > last_addr (unsigned): go to FIN with err=1, result=0, result_addr=0.
  - Otherwise: go to ISSUE.
  - result, result_addr and err are cleared on acceptance.
- ISSUE: mem_rd=1, mem_addr=cur_addr. Go to WAIT if RD_LAT>1, else to CMP.
- WAIT: holds RD_LAT-1 cycles, using a latency counter, then goes to CMP.
- CMP: mem_rdata is valid this cycle.
  - First element (cur_addr==first_addr): unconditionally loads result and result_addr.
  - Later elements: update only on a strict compare (max: rdata>result; min: rdata<result). Ties keep the earliest address.
  - If cur_addr==last_addr: go to FIN. Otherwise cur_addr+1, go to ISSUE.
  - The last-address test happens before the increment, so last_addr=2^ADDR_W-1 never wraps.
- FIN: done=1 for one cycle, busy=0, then go to IDLE.
- Signed compare sign-extends both operands by 1 bit. Unsigned compare zero-extends.
- start while busy is ignored. Latched config does not change during a run even if the inputs change.
- Timing: start sampled at edge of cycle 0 (N=last-first+1 elements).
  - Element i: ISSUE at cycle 1+i*(RD_LAT+1), CMP at 1+i*(RD_LAT+1)+RD_LAT.
  - done is high in cycle 1+N*(RD_LAT+1).
  - err case: done high in cycle 1.
- mem_rd is never asserted outside ISSUE. Exactly N reads are issued per run.

Test Plan:
1. RD_LAT=1, unsigned max, mem[0..3]={03,09,09,02}, range 0..3 -> done in cycle 9, result=09, result_addr=1 (tie keeps earliest), 4 mem_rd pulses.
2. mem[4..7]={05,F0,80,7F}: signed min -> result=80, addr=6. Unsigned max -> F0, addr=5. Unsigned min -> 05, addr=4. Signed max -> 7F, addr=7.
3. Single element first=last=A, mem[A]=3C, both modes -> result=3C, addr=A, done in cycle 1+(RD_LAT+1).
4. Full range 0..15 with max at addr 15 -> result_addr=15, exactly 16 reads, no wrap back to addr 0.
5. first=9, last=3 -> done and err in cycle 1, zero mem_rd pulses. Next valid start clears err.
6. RD_LAT=3, scan 2 elements, reset asserted in the WAIT of element 1 -> all outputs 0 next cycle, no done. A second start during a later run is ignored (done count=1, latched config unchanged).

Source files
------------

// File: rtl/minmax_scanner.sv
// -----------------------------------------------------------------------------
// minmax_scanner
//
// Scans an inclusive address range of a synchronous-read memory and returns
// the extreme value (max or min, signed or unsigned compare, chosen per run)
// together with the address where it first occurs.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        single-cycle request, only looked at in IDLE
//   mode_min     0 = find max, 1 = find min (latched at start)
//   is_signed    1 = two's-complement compare (latched at start)
//   first_addr   first address of the range (latched at start)
//   last_addr    last address of the range, inclusive (latched at start)
//   mem_addr     registered read address
//   mem_rd       read strobe, one cycle per element
//   mem_rdata    read data, valid RD_LAT cycles after mem_rd
//   busy         high while a scan is in progress
//   done         one-cycle pulse when the result is valid
//   err          set with done when first_addr > last_addr
//   result       extreme value, held until the next accepted start
//   result_addr  address of the extreme value, held likewise
// -----------------------------------------------------------------------------
module minmax_scanner #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode_min,
   input  logic              is_signed,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] result,
   output logic [ADDR_W-1:0] result_addr
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_CMP   = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   // WAIT lasts RD_LAT-1 cycles; the counter is loaded with the number of
   // extra WAIT cycles still to go after the first one.
   localparam logic [1:0] LAT_INIT = (RD_LAT > 2) ? 2'(RD_LAT - 2) : 2'd0;

   state_t            state_r;
   logic [ADDR_W-1:0] cur_addr_r;
   logic [ADDR_W-1:0] first_r;
   logic [ADDR_W-1:0] last_r;
   logic              mode_min_r;
   logic              is_signed_r;
   logic [1:0]        lat_cnt_r;
   logic              upd_s;

   // Widen by one bit: sign bit copied for signed compares, zero otherwise.
   function automatic logic [DATA_W:0] ext_val(input logic [DATA_W-1:0] v,
                                               input logic sgn);
      return {sgn & v[DATA_W-1], v};
   endfunction

   // Strict compare of a candidate against the current best.
   function automatic logic is_better(input logic [DATA_W-1:0] cand,
                                      input logic [DATA_W-1:0] best,
                                      input logic mn,
                                      input logic sgn);
      logic signed [DATA_W:0] c_v;
      logic signed [DATA_W:0] b_v;
      c_v = ext_val(cand, sgn);
      b_v = ext_val(best, sgn);
      if (mn) begin
         return (c_v < b_v);
      end else begin
         return (c_v > b_v);
      end
   endfunction

   // Decide whether the element arriving in CMP replaces the stored extreme;
   // the first element of a range always loads.
   always_comb begin
      upd_s = 1'b0;
      if (cur_addr_r == first_r) begin
         upd_s = 1'b1;
      end else begin
         upd_s = is_better(mem_rdata, result, mode_min_r, is_signed_r);
      end
   end

   // Scan controller and datapath; every output is a register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= S_IDLE;
         cur_addr_r  <= '0;
         first_r     <= '0;
         last_r      <= '0;
         mode_min_r  <= 1'b0;
         is_signed_r <= 1'b0;
         lat_cnt_r   <= 2'd0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         result      <= '0;
         result_addr <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  first_r     <= first_addr;
                  last_r      <= last_addr;
                  mode_min_r  <= mode_min;
                  is_signed_r <= is_signed;
                  cur_addr_r  <= first_addr;
                  result      <= '0;
                  result_addr <= '0;
                  if (first_addr > last_addr) begin
                     // Empty range: report straight away, no reads.
                     err     <= 1'b1;
                     done    <= 1'b1;
                     state_r <= S_FIN;
                  end else begin
                     err      <= 1'b0;
                     busy     <= 1'b1;
                     mem_rd   <= 1'b1;
                     mem_addr <= first_addr;
                     state_r  <= S_ISSUE;
                  end
               end else begin
                  state_r <= S_IDLE;
               end
            end

            S_ISSUE: begin
               mem_rd <= 1'b0;
               if (RD_LAT > 1) begin
                  lat_cnt_r <= LAT_INIT;
                  state_r   <= S_WAIT;
               end else begin
                  state_r <= S_CMP;
               end
            end

            S_WAIT: begin
               if (lat_cnt_r == 2'd0) begin
                  state_r <= S_CMP;
               end else begin
                  lat_cnt_r <= lat_cnt_r - 2'd1;
               end
            end

            S_CMP: begin
               if (upd_s) begin
                  result      <= mem_rdata;
                  result_addr <= cur_addr_r;
               end
               // Test for the end before incrementing so a range ending at
               // the top address never wraps.
               if (cur_addr_r == last_r) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= S_FIN;
               end else begin
                  cur_addr_r <= cur_addr_r + ADDR_W'(1);
                  mem_addr   <= cur_addr_r + ADDR_W'(1);
                  mem_rd     <= 1'b1;
                  state_r    <= S_ISSUE;
               end
            end

            S_FIN: begin
               done    <= 1'b0;
               state_r <= S_IDLE;
            end

            default: begin
               state_r <= S_IDLE;
               mem_rd  <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minmax_scanner.sv
// -----------------------------------------------------------------------------
// tb_minmax_scanner
//
// Drives two scanners (read latency 1 and 3) from the same host inputs and the
// same memory image, and checks results, read traffic and done timing against
// a reference model that simply walks the memory array.
// -----------------------------------------------------------------------------
module tb_minmax_scanner;

   localparam int DW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, mode_min, is_signed;
   logic [AW-1:0] first_addr, last_addr;
   logic [DW-1:0] mem [16];
   logic [DW-1:0] junk;

   logic [AW-1:0] a_addr, a_raddr, b_addr, b_raddr;
   logic          a_rd, a_busy, a_done, a_err, b_rd, b_busy, b_done, b_err;
   logic [DW-1:0] a_rdata, a_result, b_rdata, b_result;

   int n_cmp = 0;
   int n_bad = 0;

   minmax_scanner #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .mode_min(mode_min),
      .is_signed(is_signed), .first_addr(first_addr), .last_addr(last_addr),
      .mem_addr(a_addr), .mem_rd(a_rd), .mem_rdata(a_rdata), .busy(a_busy),
      .done(a_done), .err(a_err), .result(a_result), .result_addr(a_raddr));

   minmax_scanner #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) dut_b (
      .clk(clk), .reset(reset), .start(start), .mode_min(mode_min),
      .is_signed(is_signed), .first_addr(first_addr), .last_addr(last_addr),
      .mem_addr(b_addr), .mem_rd(b_rd), .mem_rdata(b_rdata), .busy(b_busy),
      .done(b_done), .err(b_err), .result(b_result), .result_addr(b_raddr));

   // Memory read ports: data is only meaningful RD_LAT cycles after mem_rd,
   // otherwise the bus carries random junk.
   always @(posedge clk) junk <= 8'($urandom);

   logic          a_v = 1'b0;
   logic [DW-1:0] a_d;
   always @(posedge clk) begin
      a_v <= a_rd;
      a_d <= mem[a_addr];
   end
   assign a_rdata = a_v ? a_d : junk;

   logic [2:0]    b_v = 3'b000;
   logic [DW-1:0] b_d [3];
   always @(posedge clk) begin
      b_v    <= {b_v[1:0], b_rd};
      b_d[0] <= mem[b_addr];
      b_d[1] <= b_d[0];
      b_d[2] <= b_d[1];
   end
   assign b_rdata = b_v[2] ? b_d[2] : junk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic int num(input logic [DW-1:0] x, input bit sg);
      return sg ? int'($signed(x)) : int'(x);
   endfunction

   // Reference: walk the range, keep the first strictly better element.
   task automatic ref_scan(input int f, input int l, input bit mn, input bit sg,
                           output int rv, output int ra);
      int best;
      best = num(mem[f], sg);
      ra   = f;
      for (int i = f + 1; i <= l; i++) begin
         if (mn ? (num(mem[i], sg) < best) : (num(mem[i], sg) > best)) begin
            best = num(mem[i], sg);
            ra   = i;
         end
      end
      rv = int'(mem[ra]);
   endtask

   task automatic scramble_inputs();
      mode_min   = 1'($urandom);
      is_signed  = 1'($urandom);
      first_addr = 4'($urandom);
      last_addr  = 4'($urandom);
   endtask

   // One run: start in cycle 0, observe every cycle up to the slower DUT's done.
   task automatic run_scan(input int f, input int l, input bit mn, input bit sg,
                           input int restart);
      int  n, exp_a, exp_b, rv, ra;
      int  a_rdc, b_rdc, a_dc, b_dc, a_dcyc, b_dcyc;
      bit  bad_range;
      bad_range = (f > l);
      n     = bad_range ? 0 : l - f + 1;
      exp_a = bad_range ? 1 : 1 + n * 2;
      exp_b = bad_range ? 1 : 1 + n * 4;
      a_rdc = 0; b_rdc = 0; a_dc = 0; b_dc = 0; a_dcyc = -1; b_dcyc = -1;
      @(negedge clk);
      start = 1'b1; mode_min = mn; is_signed = sg;
      first_addr = AW'(f); last_addr = AW'(l);
      @(negedge clk);
      for (int k = 1; k <= exp_b + 3; k++) begin
         if (k == 1) begin
            check("busy_a_c1", int'(a_busy), bad_range ? 0 : 1);
            check("busy_b_c1", int'(b_busy), bad_range ? 0 : 1);
            check("err_a_c1", int'(a_err), int'(bad_range));
            check("err_b_c1", int'(b_err), int'(bad_range));
         end
         if (a_rd) begin
            check("rdaddr_a", int'(a_addr), (f + a_rdc) & 15);
            a_rdc++;
         end
         if (b_rd) begin
            check("rdaddr_b", int'(b_addr), (f + b_rdc) & 15);
            b_rdc++;
         end
         if (a_done) begin a_dc++; a_dcyc = k; end
         if (b_done) begin b_dc++; b_dcyc = k; end
         if (k == restart) begin
            start = 1'b1; mode_min = ~mn; is_signed = ~sg;
            first_addr = 4'd0; last_addr = 4'd15;
         end else begin
            start = 1'b0;
            scramble_inputs();
         end
         @(negedge clk);
      end
      start = 1'b0;
      if (bad_range) begin
         rv = 0; ra = 0;
      end else begin
         ref_scan(f, l, mn, sg, rv, ra);
      end
      check("done_cnt_a", a_dc, 1);
      check("done_cnt_b", b_dc, 1);
      check("done_cyc_a", a_dcyc, exp_a);
      check("done_cyc_b", b_dcyc, exp_b);
      check("reads_a", a_rdc, n);
      check("reads_b", b_rdc, n);
      check("result_a", int'(a_result), rv);
      check("result_b", int'(b_result), rv);
      check("raddr_a", int'(a_raddr), ra);
      check("raddr_b", int'(b_raddr), ra);
      check("err_a", int'(a_err), int'(bad_range));
      check("err_b", int'(b_err), int'(bad_range));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a"}, int'({a_addr, a_rd, a_busy, a_done, a_err, a_result, a_raddr}), 0);
      check({tag, "_b"}, int'({b_addr, b_rd, b_busy, b_done, b_err, b_result, b_raddr}), 0);
   endtask

   // Reset in the WAIT of element 1 of the latency-3 scanner (cycle 6).
   task automatic reset_mid_scan();
      int b_dc;
      b_dc = 0;
      @(negedge clk);
      start = 1'b1; mode_min = 1'b0; is_signed = 1'b0;
      first_addr = 4'd2; last_addr = 4'd3;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         if (k == 6) begin
            check("busy_b_prerst", int'(b_busy), 1);
            reset = 1'b1;
         end else if (k == 7) begin
            check_all_zero("rst_mid");
            reset = 1'b0;
         end else if (k > 7 && b_done) begin
            b_dc++;
         end
         @(negedge clk);
      end
      check("done_after_rst_b", b_dc, 0);
   endtask

   initial begin
      int f, l;
      reset = 1'b1; start = 1'b0;
      mode_min = 1'b0; is_signed = 1'b0; first_addr = '0; last_addr = '0;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      reset = 1'b0;

      // Ties keep the earliest address.
      mem[0] = 8'h03; mem[1] = 8'h09; mem[2] = 8'h09; mem[3] = 8'h02;
      run_scan(0, 3, 1'b0, 1'b0, -1);

      // Signed and unsigned views of the same data.
      mem[4] = 8'h05; mem[5] = 8'hF0; mem[6] = 8'h80; mem[7] = 8'h7F;
      run_scan(4, 7, 1'b1, 1'b1, -1);
      run_scan(4, 7, 1'b0, 1'b0, -1);
      run_scan(4, 7, 1'b1, 1'b0, -1);
      run_scan(4, 7, 1'b0, 1'b1, -1);

      // Single element.
      mem[10] = 8'h3C;
      run_scan(10, 10, 1'b0, 1'b0, -1);
      run_scan(10, 10, 1'b1, 1'b1, -1);

      // Full range, max at the top address; second start mid-run is ignored.
      for (int i = 0; i < 15; i++) mem[i] = 8'($urandom_range(0, 254));
      mem[15] = 8'hFF;
      run_scan(0, 15, 1'b0, 1'b0, 3);

      // Empty range, then a valid run clears err.
      run_scan(9, 3, 1'b0, 1'b0, -1);
      run_scan(1, 2, 1'b1, 1'b0, -1);

      reset_mid_scan();

      // Random runs.
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
         if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 15)] = mem[$urandom_range(0, 15)];
         f = $urandom_range(0, 15);
         l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(f, 15);
         run_scan(f, l, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) == 0 && l - f >= 2) ? 3 : -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
